seg_capture: RTL and testbench

- Host-side reader for the chip's 7-segment output bus. It is the receiving end of the segment encoder on the DUT's io_out.
- Samples io_out[6:0] (segments) and io_out[7] (dp), and requires a pattern to be stable before accepting it. Accepted patterns are decoded to hex nibbles.
- Decoded digits are queued in a small first-word-fall-through (FWFT) FIFO with a valid/ready interface, for a scoreboard or host logic.
- Sits alongside the top-level wrapper in board/FPGA test harnesses.

---
 rtl/seg_capture.sv | 181 ++++++++++++++++++
 tb/tb_seg_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Host-side reader for a 7-segment output bus: debounces the sampled pattern,
// decodes accepted digits to hex nibbles and queues them in a small FWFT FIFO.
module seg_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [6:0]                    seg_in,
    input  logic                          dp_in,
    input  logic                          enable,
    output logic                          digit_valid,
    input  logic                          digit_ready,
    output logic [3:0]                    digit_data,
    output logic                          digit_dp,
    output logic                          digit_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Returns {err, nibble}; unknown non-blank shapes decode to 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = {1'b0, 4'h0};
            7'h06:   decode = {1'b0, 4'h1};
            7'h5B:   decode = {1'b0, 4'h2};
            7'h4F:   decode = {1'b0, 4'h3};
            7'h66:   decode = {1'b0, 4'h4};
            7'h6D:   decode = {1'b0, 4'h5};
            7'h7D:   decode = {1'b0, 4'h6};
            7'h07:   decode = {1'b0, 4'h7};
            7'h7F:   decode = {1'b0, 4'h8};
            7'h6F:   decode = {1'b0, 4'h9};
            7'h77:   decode = {1'b0, 4'hA};
            7'h7C:   decode = {1'b0, 4'hB};
            7'h39:   decode = {1'b0, 4'hC};
            7'h5E:   decode = {1'b0, 4'hD};
            7'h79:   decode = {1'b0, 4'hE};
            7'h71:   decode = {1'b0, 4'hF};
            default: decode = {1'b1, 4'h0};
        endcase
    endfunction

    logic [7:0]    sample_q, sample_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    last_q, last_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [5:0]    mem [FIFO_DEPTH];

    logic [7:0] sample_in;
    logic       changed;
    logic       accept;
    logic       push;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic [4:0] dec;
    logic [5:0] head;

    assign sample_in = {dp_in, seg_in};
    assign changed   = (sample_in != sample_q);
    assign accept    = (cnt_q == CNT_MAX);
    assign dec       = decode(sample_q[6:0]);

    // Debounce and acceptance FSM.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        last_d   = last_q;
        push     = 1'b0;
        if (!enable) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            last_d  = '0;
        end else begin
            sample_d = sample_in;
            if (changed)
                cnt_d = '0;
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CW'(1);
            case (state_q)
                ST_IDLE: begin
                    if (sample_q[6:0] != 7'h00)
                        state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (accept) begin
                        if (sample_q[6:0] == 7'h00) begin
                            last_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            if (sample_q != last_q) begin
                                push   = 1'b1;
                                last_d = sample_q;
                            end
                            // A new pattern arriving on the accept edge must keep tracking.
                            state_d = changed ? ST_TRACK : ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (changed)
                        state_d = ST_TRACK;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO control: a push into a full queue only lands if a pop frees a slot.
    always_comb begin
        full       = (count_q == COUNT_FULL);
        pop        = digit_valid && digit_ready;
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push && full && !pop);
        if (wr_en)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !wr_en)
            count_d = count_q - (AW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_q   <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; an empty queue masks it from the outputs.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr_q] <= {dec[4], sample_q[7], dec[3:0]};
    end

    assign head        = mem[rd_ptr_q];
    assign digit_valid = (count_q != '0);
    assign digit_data  = digit_valid ? head[3:0] : 4'h0;
    assign digit_dp    = digit_valid ? head[4]   : 1'b0;
    assign digit_err   = digit_valid ? head[5]   : 1'b0;
    assign overflow    = overflow_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: debounce latency, glitch rejection, dp/err
// capture, overflow, full push+pop and mid-run reset.
module tb_seg_capture;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       dp_in;
    logic       enable;
    logic       digit_valid;
    logic       digit_ready;
    logic [3:0] digit_data;
    logic       digit_dp;
    logic       digit_err;
    logic       overflow;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    seg_capture #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .enable      (enable),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_data  (digit_data),
        .digit_dp    (digit_dp),
        .digit_err   (digit_err),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [6:0] seg, input logic dp, input int n);
        seg_in = seg;
        dp_in  = dp;
        step(n);
    endtask

    task automatic pop_check(input string tag, input logic [3:0] d, input logic p, input logic e);
        check({tag, "_valid"}, 32'(digit_valid), 32'd1);
        check({tag, "_data"},  32'(digit_data),  32'(d));
        check({tag, "_dp"},    32'(digit_dp),    32'(p));
        check({tag, "_err"},   32'(digit_err),   32'(e));
        digit_ready = 1'b1;
        step(1);
        digit_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; seg_in = 7'h00; dp_in = 1'b0; digit_ready = 1'b0;
        step(2);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_count", 32'(fifo_count),  32'd0);
        check("rst_ovf",   32'(overflow),    32'd0);
        check("rst_data",  32'(digit_data),  32'd0);
        reset = 1'b1;
        enable = 1'b1;

        // Latency: push lands on edge 5 after the pattern is first registered.
        hold(7'h5B, 1'b0, 4);
        check("lat_edge4_valid", 32'(digit_valid), 32'd0);
        step(1);
        check("lat_edge5_valid", 32'(digit_valid), 32'd1);
        check("lat_data",  32'(digit_data), 32'h2);
        check("lat_err",   32'(digit_err),  32'd0);
        check("lat_count", 32'(fifo_count), 32'd1);
        step(100);
        check("hold100_count", 32'(fifo_count), 32'd1);
        pop_check("lat_pop", 4'h2, 1'b0, 1'b0);
        check("lat_empty", 32'(fifo_count), 32'd0);
        hold(7'h00, 1'b0, 8);

        // Glitch: 0x06 never stays long enough to be accepted.
        hold(7'h06, 1'b0, 3);
        hold(7'h4F, 1'b0, 10);
        check("glitch_count", 32'(fifo_count), 32'd1);
        pop_check("glitch_pop", 4'h3, 1'b0, 1'b0);
        check("glitch_empty", 32'(fifo_count), 32'd0);
        hold(7'h00, 1'b0, 8);

        // Blank re-arm, dp-only change, and unknown pattern.
        hold(7'h3F, 1'b0, 8);
        hold(7'h00, 1'b0, 8);
        hold(7'h3F, 1'b0, 8);
        hold(7'h3F, 1'b1, 8);
        hold(7'h12, 1'b0, 8);
        check("seq_count", 32'(fifo_count), 32'd4);
        check("seq_ovf",   32'(overflow),   32'd0);
        pop_check("seq0", 4'h0, 1'b0, 1'b0);
        pop_check("seq1", 4'h0, 1'b0, 1'b0);
        pop_check("seq2", 4'h0, 1'b1, 1'b0);
        pop_check("seq3", 4'h0, 1'b0, 1'b1);
        hold(7'h00, 1'b0, 8);

        // Overflow: fifth digit is dropped.
        hold(7'h06, 1'b0, 8);
        hold(7'h5B, 1'b0, 8);
        hold(7'h4F, 1'b0, 8);
        hold(7'h66, 1'b0, 8);
        hold(7'h6D, 1'b0, 8);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag",  32'(overflow),   32'd1);
        pop_check("ovf0", 4'h1, 1'b0, 1'b0);
        pop_check("ovf1", 4'h2, 1'b0, 1'b0);
        pop_check("ovf2", 4'h3, 1'b0, 1'b0);
        pop_check("ovf3", 4'h4, 1'b0, 1'b0);
        check("ovf_drained", 32'(fifo_count), 32'd0);
        check("ovf_sticky",  32'(overflow),   32'd1);
        digit_ready = 1'b1;
        step(1);
        digit_ready = 1'b0;
        check("pop_empty_count", 32'(fifo_count), 32'd0);
        hold(7'h00, 1'b0, 8);

        // Mid-run reset discards queued digits and clears overflow.
        hold(7'h07, 1'b0, 8);
        hold(7'h7F, 1'b0, 8);
        hold(7'h6F, 1'b0, 8);
        check("prerst_count", 32'(fifo_count), 32'd3);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("midrst_valid", 32'(digit_valid), 32'd0);
        check("midrst_count", 32'(fifo_count),  32'd0);
        check("midrst_ovf",   32'(overflow),    32'd0);
        hold(7'h77, 1'b0, 4);
        check("a_edge4_valid", 32'(digit_valid), 32'd0);
        step(1);
        pop_check("a_pop", 4'hA, 1'b0, 1'b0);
        hold(7'h00, 1'b0, 8);

        // Full FIFO with a pop on the push edge: nothing lost, no overflow.
        hold(7'h06, 1'b0, 8);
        hold(7'h5B, 1'b0, 8);
        hold(7'h4F, 1'b0, 8);
        hold(7'h66, 1'b0, 8);
        check("full_count", 32'(fifo_count), 32'd4);
        hold(7'h6D, 1'b0, 4);
        check("full_edge4_count", 32'(fifo_count), 32'd4);
        digit_ready = 1'b1;
        step(1);
        digit_ready = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf",   32'(overflow),   32'd0);
        pop_check("pp0", 4'h2, 1'b0, 1'b0);
        pop_check("pp1", 4'h3, 1'b0, 1'b0);
        pop_check("pp2", 4'h4, 1'b0, 1'b0);
        pop_check("pp3", 4'h5, 1'b0, 1'b0);
        check("pp_empty", 32'(fifo_count), 32'd0);

        // enable low freezes capture; re-enabling starts a fresh 5-edge window.
        enable = 1'b0;
        hold(7'h39, 1'b0, 10);
        check("dis_count", 32'(fifo_count), 32'd0);
        enable = 1'b1;
        step(4);
        check("en_edge4_valid", 32'(digit_valid), 32'd0);
        step(1);
        pop_check("en_pop", 4'hC, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
